// File: rtl/serial_reg_unit.sv
// Two N-bit serial shift registers (A, B) with the control FSM that runs exactly
// N right-shifts per Execute request, then holds until Execute is released.
module serial_reg_unit #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_execute,
  input  logic         i_load_a,
  input  logic         i_load_b,
  input  logic [N-1:0] i_din,
  input  logic         i_a_shift_in,
  input  logic         i_b_shift_in,
  output logic         o_a_lsb,
  output logic         o_b_lsb,
  output logic [N-1:0] o_a,
  output logic [N-1:0] o_b,
  output logic         o_busy,
  output logic         o_done
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          w_last_shift;

  assign w_last_shift = (r_count == LAST_COUNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A load coinciding with Execute still lands, so the first shift sees it.
          if (i_load_a) r_a <= i_din;
          if (i_load_b) r_b <= i_din;
          if (i_execute) begin
            r_state <= S_SHIFT;
            r_count <= '0;
          end
        end
        S_SHIFT: begin
          r_a <= {i_a_shift_in, r_a[N-1:1]};
          r_b <= {i_b_shift_in, r_b[N-1:1]};
          if (w_last_shift) begin
            r_state <= S_HOLD;
            r_count <= '0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_HOLD: begin
          if (!i_execute) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_a_lsb = r_a[0];
  assign o_b_lsb = r_b[0];
  assign o_busy  = (r_state == S_SHIFT);
  assign o_done  = (r_state == S_HOLD);

endmodule

// File: tb/tb_serial_reg_unit.sv
// Directed bench for serial_reg_unit: table-driven vectors plus hand-written
// sequences for the feedback swap and an asynchronous reset mid-operation.
module tb_serial_reg_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       execute, load_a, load_b;
  logic [7:0] din;
  logic       a_si, b_si, fb;
  logic       w_a_si, w_b_si;
  logic       a_lsb, b_lsb, busy, done;
  logic [7:0] a_q, b_q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Feedback mode routes each register's LSB into the other's MSB (swap).
  assign w_a_si = fb ? b_lsb : a_si;
  assign w_b_si = fb ? a_lsb : b_si;

  serial_reg_unit #(.N(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_execute(execute),
    .i_load_a(load_a), .i_load_b(load_b), .i_din(din),
    .i_a_shift_in(w_a_si), .i_b_shift_in(w_b_si),
    .o_a_lsb(a_lsb), .o_b_lsb(b_lsb), .o_a(a_q), .o_b(b_q),
    .o_busy(busy), .o_done(done)
  );

  typedef struct {
    logic       la, lb, ex;
    logic [7:0] din;
    logic       asi, bsi;
    logic [7:0] ea, eb;
    logic       ebusy, edone;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic la, input logic lb, input logic ex, input logic [7:0] d,
                     input logic asi, input logic bsi, input logic [7:0] ea,
                     input logic [7:0] eb, input logic ebusy, input logic edone);
    vec_t v;
    v.la = la; v.lb = lb; v.ex = ex; v.din = d; v.asi = asi; v.bsi = bsi;
    v.ea = ea; v.eb = eb; v.ebusy = ebusy; v.edone = edone;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tv.size(); i++) begin
      load_a = tv[i].la; load_b = tv[i].lb; execute = tv[i].ex; din = tv[i].din;
      a_si = tv[i].asi; b_si = tv[i].bsi;
      step();
      $display("%s row %0d: A=%02h B=%02h busy=%0b done=%0b", tag, i, a_q, b_q, busy, done);
      chk($sformatf("%s[%0d].A", tag, i), a_q, tv[i].ea);
      chk($sformatf("%s[%0d].B", tag, i), b_q, tv[i].eb);
      chk($sformatf("%s[%0d].A_Lsb", tag, i), {7'd0, a_lsb}, {7'd0, tv[i].ea[0]});
      chk($sformatf("%s[%0d].B_Lsb", tag, i), {7'd0, b_lsb}, {7'd0, tv[i].eb[0]});
      chk($sformatf("%s[%0d].Busy", tag, i), {7'd0, busy}, {7'd0, tv[i].ebusy});
      chk($sformatf("%s[%0d].Done", tag, i), {7'd0, done}, {7'd0, tv[i].edone});
    end
    tv.delete();
  endtask

  initial begin
    int n_busy;
    rst_n = 1'b0; execute = 0; load_a = 0; load_b = 0; din = 8'h00;
    a_si = 0; b_si = 0; fb = 0;
    #12;
    $display("reset: A=%02h B=%02h busy=%0b done=%0b", a_q, b_q, busy, done);
    chk("rst.A", a_q, 8'h00);
    chk("rst.B", b_q, 8'h00);
    chk("rst.Busy", {7'd0, busy}, 8'h00);
    chk("rst.Done", {7'd0, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Parallel loads in IDLE.
    add(1,0,0,8'h33,0,0, 8'h33,8'h00,0,0);
    add(0,1,0,8'h55,0,0, 8'h33,8'h55,0,0);
    run_table("load");

    // Swap through feedback: Busy must last exactly 8 cycles.
    fb = 1; execute = 1;
    step();
    $display("swap start: busy=%0b", busy);
    chk("swap.BusyStart", {7'd0, busy}, 8'h01);
    n_busy = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (busy) n_busy++;
      else break;
    end
    $display("swap end: busy_cycles=%0d A=%02h B=%02h done=%0b", n_busy, a_q, b_q, done);
    chk("swap.BusyCycles", 8'(n_busy), 8'd8);
    chk("swap.A", a_q, 8'h55);
    chk("swap.B", b_q, 8'h33);
    chk("swap.Done", {7'd0, done}, 8'h01);
    fb = 0;

    // HOLD ignores loads and does not retrigger; release then retrigger.
    for (int k = 0; k < 5; k++) add(1,0,1,8'hAA,0,0, 8'h55,8'h33,0,1);
    add(0,0,0,8'h00,0,0, 8'h55,8'h33,0,0);
    add(0,0,1,8'h00,1,1, 8'h55,8'h33,1,0);
    add(0,0,0,8'h00,1,1, 8'hAA,8'h99,1,0);
    add(0,0,0,8'h00,1,1, 8'hD5,8'hCC,1,0);
    add(0,0,0,8'h00,1,1, 8'hEA,8'hE6,1,0);
    add(0,0,0,8'h00,1,1, 8'hF5,8'hF3,1,0);
    add(0,0,0,8'h00,1,1, 8'hFA,8'hF9,1,0);
    add(0,0,0,8'h00,1,1, 8'hFD,8'hFC,1,0);
    add(0,0,0,8'h00,1,1, 8'hFE,8'hFE,1,0);
    add(0,0,0,8'h00,1,1, 8'hFF,8'hFF,0,1);
    add(0,0,0,8'h00,0,0, 8'hFF,8'hFF,0,0);
    run_table("hold");

    // Constant shift-in with a one-cycle Execute pulse.
    add(1,0,0,8'h00,0,0, 8'h00,8'hFF,0,0);
    add(0,1,0,8'hFF,0,0, 8'h00,8'hFF,0,0);
    add(0,0,1,8'h00,1,0, 8'h00,8'hFF,1,0);
    add(0,0,0,8'h00,1,0, 8'h80,8'h7F,1,0);
    add(0,0,0,8'h00,1,0, 8'hC0,8'h3F,1,0);
    add(0,0,0,8'h00,1,0, 8'hE0,8'h1F,1,0);
    add(0,0,0,8'h00,1,0, 8'hF0,8'h0F,1,0);
    add(0,0,0,8'h00,1,0, 8'hF8,8'h07,1,0);
    add(0,0,0,8'h00,1,0, 8'hFC,8'h03,1,0);
    add(0,0,0,8'h00,1,0, 8'hFE,8'h01,1,0);
    add(0,0,0,8'h00,1,0, 8'hFF,8'h00,0,1);
    add(0,0,0,8'h00,0,0, 8'hFF,8'h00,0,0);
    // Load and Execute together: first shift acts on the loaded value.
    add(1,0,1,8'h01,0,0, 8'h01,8'h00,1,0);
    for (int k = 0; k < 7; k++) add(0,0,0,8'h00,0,0, 8'h00,8'h00,1,0);
    add(0,0,0,8'h00,0,0, 8'h00,8'h00,0,1);
    add(0,0,0,8'h00,0,0, 8'h00,8'h00,0,0);
    add(1,0,0,8'hFF,0,0, 8'hFF,8'h00,0,0);
    run_table("ops");

    // Asynchronous reset in the middle of a shift.
    execute = 1; a_si = 1; b_si = 1;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    $display("mid reset: A=%02h B=%02h busy=%0b done=%0b", a_q, b_q, busy, done);
    chk("areset.A", a_q, 8'h00);
    chk("areset.B", b_q, 8'h00);
    chk("areset.A_Lsb", {7'd0, a_lsb}, 8'h00);
    chk("areset.Busy", {7'd0, busy}, 8'h00);
    chk("areset.Done", {7'd0, done}, 8'h00);
    execute = 0;
    @(negedge clk);
    rst_n = 1'b1;
    load_a = 1; din = 8'h0F;
    step();
    $display("after reset: A=%02h busy=%0b done=%0b", a_q, busy, done);
    chk("post.A", a_q, 8'h0F);
    chk("post.Busy", {7'd0, busy}, 8'h00);
    chk("post.Done", {7'd0, done}, 8'h00);
    load_a = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
